// File: rtl/acc_drain_pkg.sv
// Shared types and default sizing for the accumulate-and-drain controller.
package acc_drain_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_ACCUM = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

   localparam int DEF_BUF_SIZE = 32;
   localparam int DEF_BUF_NUM  = 32;

   // A requested pass count of zero still runs one pass.
   function automatic logic [7:0] eff_pass_num(input logic [7:0] pn);
      return (pn == 8'd0) ? 8'd1 : pn;
   endfunction

endpackage

// File: rtl/acc_drain_ctrl.sv
// Tile controller: clears an external accumulation buffer, performs
// read-modify-write accumulation of partial sums over a number of passes,
// then drains every entry through a valid/ready port.
module acc_drain_ctrl
   import acc_drain_pkg::*;
#(
   parameter int BUF_SIZE = DEF_BUF_SIZE,
   parameter int BUF_NUM  = DEF_BUF_NUM,
   parameter int IW       = $clog2(BUF_NUM)
)(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic [7:0]          pass_num_i,
   output logic                busy_o,
   output logic                done_o,
   input  logic                psum_val_i,
   output logic                psum_rdy_o,
   input  logic [IW-1:0]       psum_sel_i,
   input  logic [BUF_SIZE-1:0] psum_dat_i,
   input  logic                psum_last_i,
   output logic [IW-1:0]       buf_acc_sel_o,
   output logic                buf_acc_val_o,
   output logic [BUF_SIZE-1:0] buf_acc_dat_o,
   input  logic [BUF_SIZE-1:0] buf_acc_dat_i,
   output logic [IW-1:0]       buf_out_sel_o,
   input  logic [BUF_SIZE-1:0] buf_out_dat_i,
   output logic                out_val_o,
   input  logic                out_rdy_i,
   output logic [IW-1:0]       out_idx_o,
   output logic [BUF_SIZE-1:0] out_dat_o
);

   localparam logic [IW-1:0] LAST_IDX = IW'(BUF_NUM - 1);
   localparam logic [IW-1:0] ONE_IDX  = IW'(1);

   state_e        state_r;
   state_e        state_s;
   logic [7:0]    pass_num_r;
   logic [7:0]    pass_cnt_r;
   logic [IW-1:0] clr_idx_r;
   logic [IW-1:0] drn_idx_r;
   logic          done_r;

   logic          xfer_s;
   logic          last_pass_s;
   logic          clr_end_s;
   logic          drn_end_s;

   // Event decode: beat transfer, final pass completion, end of clear/drain.
   always_comb begin
      xfer_s      = (state_r == ST_ACCUM) && psum_val_i;
      last_pass_s = xfer_s && psum_last_i && ((pass_cnt_r + 8'd1) == pass_num_r);
      clr_end_s   = (state_r == ST_CLEAR) && (clr_idx_r == LAST_IDX);
      drn_end_s   = (state_r == ST_DRAIN) && out_rdy_i && (drn_idx_r == LAST_IDX);
   end

   // Next-state and output decode; every output parks at zero in IDLE.
   always_comb begin
      state_s       = state_r;
      psum_rdy_o    = 1'b0;
      buf_acc_sel_o = '0;
      buf_acc_val_o = 1'b0;
      buf_acc_dat_o = '0;
      buf_out_sel_o = '0;
      out_val_o     = 1'b0;
      out_idx_o     = '0;
      out_dat_o     = '0;
      case (state_r)
         ST_IDLE: begin
            if (start_i) begin
               state_s = ST_CLEAR;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            buf_acc_sel_o = clr_idx_r;
            buf_acc_val_o = 1'b1;
            if (clr_end_s) begin
               state_s = ST_ACCUM;
            end else begin
               state_s = ST_CLEAR;
            end
         end
         ST_ACCUM: begin
            psum_rdy_o    = 1'b1;
            buf_acc_sel_o = psum_sel_i;
            // The buffer write lands at the edge, so the next beat's
            // combinational read already sees the updated value.
            buf_acc_dat_o = buf_acc_dat_i + psum_dat_i;
            if (psum_val_i) begin
               buf_acc_val_o = 1'b1;
            end else begin
               buf_acc_val_o = 1'b0;
            end
            if (last_pass_s) begin
               state_s = ST_DRAIN;
            end else begin
               state_s = ST_ACCUM;
            end
         end
         ST_DRAIN: begin
            out_val_o     = 1'b1;
            buf_out_sel_o = drn_idx_r;
            out_idx_o     = drn_idx_r;
            out_dat_o     = buf_out_dat_i;
            if (drn_end_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, pass counter, clear/drain indices and the done pulse register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r    <= ST_IDLE;
         pass_num_r <= 8'd0;
         pass_cnt_r <= 8'd0;
         clr_idx_r  <= '0;
         drn_idx_r  <= '0;
         done_r     <= 1'b0;
      end else begin
         state_r <= state_s;
         done_r  <= drn_end_s;
         case (state_r)
            ST_IDLE: begin
               if (start_i) begin
                  pass_num_r <= eff_pass_num(pass_num_i);
                  pass_cnt_r <= 8'd0;
                  clr_idx_r  <= '0;
                  drn_idx_r  <= '0;
               end
            end
            ST_CLEAR: begin
               clr_idx_r <= clr_end_s ? '0 : (clr_idx_r + ONE_IDX);
            end
            ST_ACCUM: begin
               if (xfer_s && psum_last_i) begin
                  pass_cnt_r <= pass_cnt_r + 8'd1;
               end
               if (last_pass_s) begin
                  drn_idx_r <= '0;
               end
            end
            ST_DRAIN: begin
               if (out_rdy_i) begin
                  drn_idx_r <= drn_end_s ? '0 : (drn_idx_r + ONE_IDX);
               end
            end
            default: begin
               drn_idx_r <= '0;
            end
         endcase
      end
   end

   assign busy_o = (state_r != ST_IDLE);
   assign done_o = done_r;

endmodule

// File: tb/tb_acc_drain_ctrl.sv
// Scoreboard bench for acc_drain_ctrl with a behavioural buffer beside it.
module tb_acc_drain_ctrl;

   localparam int BN = 32;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic [7:0]  pass_num_i = 8'd0;
   logic        busy_o, done_o;
   logic        psum_val_i = 1'b0;
   logic        psum_rdy_o;
   logic [4:0]  psum_sel_i = 5'd0;
   logic [31:0] psum_dat_i = 32'd0;
   logic        psum_last_i = 1'b0;
   logic [4:0]  buf_acc_sel_o;
   logic        buf_acc_val_o;
   logic [31:0] buf_acc_dat_o;
   logic [31:0] buf_acc_dat_i;
   logic [4:0]  buf_out_sel_o;
   logic [31:0] buf_out_dat_i;
   logic        out_val_o;
   logic        out_rdy_i = 1'b0;
   logic [4:0]  out_idx_o;
   logic [31:0] out_dat_o;

   typedef struct {
      logic [4:0]  idx;
      logic [31:0] dat;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] mem [0:BN-1];
   logic [31:0] model [0:BN-1];
   logic        mem_init = 1'b1;
   int          total = 0;
   int          bad = 0;
   int          accepts = 0;
   int          done_cnt = 0;
   int          rdy_mode = 0;
   int          rdy_cyc = 0;
   logic        prev_stall = 1'b0;
   logic        prev_done = 1'b0;
   logic [4:0]  prev_idx = 5'd0;
   logic [31:0] prev_dat = 32'd0;

   acc_drain_ctrl dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pass_num_i(pass_num_i),
      .busy_o(busy_o), .done_o(done_o),
      .psum_val_i(psum_val_i), .psum_rdy_o(psum_rdy_o), .psum_sel_i(psum_sel_i),
      .psum_dat_i(psum_dat_i), .psum_last_i(psum_last_i),
      .buf_acc_sel_o(buf_acc_sel_o), .buf_acc_val_o(buf_acc_val_o),
      .buf_acc_dat_o(buf_acc_dat_o), .buf_acc_dat_i(buf_acc_dat_i),
      .buf_out_sel_o(buf_out_sel_o), .buf_out_dat_i(buf_out_dat_i),
      .out_val_o(out_val_o), .out_rdy_i(out_rdy_i), .out_idx_o(out_idx_o),
      .out_dat_o(out_dat_o)
   );

   // Free-running clock.
   always #5 clk_i = ~clk_i;

   // Buffer: combinational reads, writes at the clock edge, garbage preload.
   always @(posedge clk_i) begin
      if (mem_init) begin
         for (int i = 0; i < BN; i++) mem[i] <= 32'hDEAD_0000 | i;
      end else if (buf_acc_val_o) begin
         mem[buf_acc_sel_o] <= buf_acc_dat_o;
      end
   end
   assign buf_acc_dat_i = mem[buf_acc_sel_o];
   assign buf_out_dat_i = mem[buf_out_sel_o];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drain-ready driver: always ready, or the 1,0,0 repeating pattern.
   initial begin
      forever begin
         @(posedge clk_i);
         #1;
         rdy_cyc++;
         out_rdy_i = (rdy_mode == 0) ? 1'b1 : ((rdy_cyc % 3) == 0);
      end
   end

   // Monitor: pop and compare on each accepted drain beat, check stall stability and done width.
   always @(negedge clk_i) begin
      exp_t e;
      if (out_val_o && out_rdy_i) begin
         if (sb_q.size() == 0) begin
            check("drain_unexpected_beat", {59'd0, out_idx_o}, 64'hFFFF);
         end else begin
            e = sb_q.pop_front();
            check("drain_idx", {59'd0, out_idx_o}, {59'd0, e.idx});
            check("drain_dat", {32'd0, out_dat_o}, {32'd0, e.dat});
            accepts++;
         end
      end
      if (prev_stall && out_val_o) begin
         check("stall_idx_stable", {59'd0, out_idx_o}, {59'd0, prev_idx});
         check("stall_dat_stable", {32'd0, out_dat_o}, {32'd0, prev_dat});
      end
      prev_stall = out_val_o && !out_rdy_i;
      prev_idx   = out_idx_o;
      prev_dat   = out_dat_o;
      if (done_o) begin
         done_cnt++;
         if (prev_done) check("done_pulse_width", 64'd2, 64'd1);
      end
      prev_done = done_o;
   end

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, {63'd0, busy_o}, 64'd0);
      check({tag, "_done"}, {63'd0, done_o}, 64'd0);
      check({tag, "_psum_rdy"}, {63'd0, psum_rdy_o}, 64'd0);
      check({tag, "_out_val"}, {63'd0, out_val_o}, 64'd0);
      check({tag, "_acc_val"}, {63'd0, buf_acc_val_o}, 64'd0);
      check({tag, "_idx_outs"}, {49'd0, buf_acc_sel_o, buf_out_sel_o, out_idx_o}, 64'd0);
      check({tag, "_dat_outs"}, {buf_acc_dat_o, out_dat_o}, 64'd0);
   endtask

   task automatic start_tile(input logic [7:0] pn);
      int n = 0;
      int clr_bad = 0;
      for (int i = 0; i < BN; i++) model[i] = 32'd0;
      accepts = 0;
      start_i = 1'b1;
      pass_num_i = pn;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      for (int k = 0; k < 64; k++) begin
         @(negedge clk_i);
         if (psum_rdy_o) break;
         if (k == 0) check("busy_rise", {63'd0, busy_o}, 64'd1);
         if (!(buf_acc_val_o === 1'b1 && buf_acc_dat_o === 32'd0 && buf_acc_sel_o === 5'(n)))
            clr_bad++;
         n++;
      end
      check("clear_cycles", 64'(n), 64'd32);
      check("clear_write_errors", 64'(clr_bad), 64'd0);
      check("psum_rdy_after_clear", {63'd0, psum_rdy_o}, 64'd1);
   endtask

   task automatic beat(input logic [4:0] sel, input logic [31:0] dat, input logic last);
      psum_val_i  = 1'b1;
      psum_sel_i  = sel;
      psum_dat_i  = dat;
      psum_last_i = last;
      model[sel]  = model[sel] + dat;
      @(posedge clk_i);
      #1;
      psum_val_i  = 1'b0;
      psum_last_i = 1'b0;
      psum_dat_i  = 32'd0;
   endtask

   task automatic push_expected();
      for (int i = 0; i < BN; i++) sb_q.push_back('{idx: 5'(i), dat: model[i]});
   endtask

   task automatic wait_done();
      int d0 = done_cnt;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk_i);
         if (done_o) break;
      end
      check("done_seen", {63'd0, done_o}, 64'd1);
      check("idle_at_done", {63'd0, busy_o}, 64'd0);
      check("drain_beats", 64'(accepts), 64'd32);
      check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      @(negedge clk_i);
      check("done_one_cycle", {63'd0, done_o}, 64'd0);
      check("done_count", 64'(done_cnt - d0), 64'd1);
   endtask

   // Global time limit.
   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Directed stimulus.
   initial begin
      int d0;
      logic hit;
      repeat (3) @(negedge clk_i);
      check_idle_outputs("in_reset");
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      mem_init = 1'b0;
      @(negedge clk_i);
      check_idle_outputs("after_reset");

      // Tile A: one pass, single beat.
      rdy_mode = 0;
      start_tile(8'd1);
      beat(5'd7, 32'h0000_0055, 1'b1);
      push_expected();
      wait_done();

      // Tile B: two passes, same-index accumulation, start ignored, stalled drain.
      start_tile(8'd2);
      psum_sel_i = 5'd9;
      @(negedge clk_i);
      check("accum_idle_acc_val", {63'd0, buf_acc_val_o}, 64'd0);
      check("accum_idle_sel", {59'd0, buf_acc_sel_o}, 64'd9);
      beat(5'd5, 32'd3, 1'b0);
      beat(5'd5, 32'd4, 1'b1);
      @(negedge clk_i);
      check("pass1_still_accum", {63'd0, psum_rdy_o}, 64'd1);
      start_i = 1'b1;
      pass_num_i = 8'd1;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      @(negedge clk_i);
      check("start_ignored_accum", {62'd0, psum_rdy_o, busy_o}, 64'd3);
      rdy_mode = 1;
      beat(5'd5, 32'd10, 1'b1);
      push_expected();
      @(negedge clk_i);
      check("drain_entered", {63'd0, out_val_o}, 64'd1);
      check("model_idx5", {32'd0, model[5]}, 64'd17);
      wait_done();
      rdy_mode = 0;

      // Tile C: pass count zero acts as one; wraparound add.
      start_tile(8'd0);
      beat(5'd0, 32'hFFFF_FFFF, 1'b0);
      beat(5'd0, 32'd2, 1'b1);
      push_expected();
      wait_done();

      // Tile D: reset pulsed while draining index 10.
      start_tile(8'd1);
      beat(5'd10, 32'h0000_AAAA, 1'b1);
      push_expected();
      hit = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk_i);
         if (out_val_o && out_idx_o == 5'd10) begin
            hit = 1'b1;
            break;
         end
      end
      check("reached_idx10", {63'd0, hit}, 64'd1);
      d0 = done_cnt;
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      check_idle_outputs("mid_drain_reset");
      sb_q.delete();
      repeat (4) @(negedge clk_i);
      check("no_done_after_abort", 64'(done_cnt - d0), 64'd0);
      check("idle_after_abort", {63'd0, busy_o}, 64'd0);

      // Tile E: normal run after the aborted tile.
      start_tile(8'd1);
      beat(5'd31, 32'h0000_1234, 1'b0);
      beat(5'd0, 32'd9, 1'b1);
      push_expected();
      wait_done();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
